// File: rtl/pe_buffer_loader_pkg.sv
// Shared types and constants for the PE buffer loader: FSM state encoding,
// buffer select values and a small width helper.
package pe_buffer_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } loader_state_e;

  localparam logic SEL_DATA   = 1'b0;
  localparam logic SEL_WEIGHT = 1'b1;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pe_addr_counter.sv
// Loadable write-address counter; increments wrap modulo 2^width.
module pe_addr_counter #(
  parameter int width = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             inc,
  input  logic [width-1:0] load_value,
  output logic [width-1:0] value
);

  logic [width-1:0] value_q, value_d;

  always_comb begin
    value_d = value_q;
    if (load) begin
      value_d = load_value;
    end else if (inc) begin
      value_d = value_q + width'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/pe_buffer_loader.sv
// Fill engine for one PE's data/weight buffers: streams a counted burst of
// words from a valid/ready port into the selected buffer at incrementing addresses.
module pe_buffer_loader
  import pe_buffer_loader_pkg::*;
#(
  parameter int dataLen       = 32,
  parameter int dataAddrLen   = 5,
  parameter int weightAddrLen = 5,
  parameter int cntLen        = 6,
  localparam int maxAddrLen   = max_int(dataAddrLen, weightAddrLen)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     sel,
  input  logic [maxAddrLen-1:0]    base_addr,
  input  logic [cntLen-1:0]        count,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [dataLen-1:0]       in_data,
  output logic                     busy,
  output logic                     done,
  output logic                     data_wrt,
  output logic [dataAddrLen-1:0]   data_wrt_addr,
  output logic [dataLen-1:0]       data_wr_data,
  output logic                     weight_wrt,
  output logic [weightAddrLen-1:0] weight_wrt_addr,
  output logic [dataLen-1:0]       weight_wr_data
);

  loader_state_e            state_q, state_d;
  logic                     sel_q, sel_d;
  logic [cntLen-1:0]        remaining_q, remaining_d;
  logic                     done_q, done_d;
  logic                     data_wrt_q, data_wrt_d;
  logic [dataAddrLen-1:0]   data_addr_q, data_addr_d;
  logic [dataLen-1:0]       data_wdata_q, data_wdata_d;
  logic                     weight_wrt_q, weight_wrt_d;
  logic [weightAddrLen-1:0] weight_addr_q, weight_addr_d;
  logic [dataLen-1:0]       weight_wdata_q, weight_wdata_d;

  logic                     accept;
  logic                     cnt_load;
  logic [maxAddrLen-1:0]    cur_addr;

  assign accept   = in_valid && (state_q == ST_LOAD);
  assign cnt_load = (state_q == ST_IDLE) && start && (count != '0);

  // Counter runs at the wider width; slicing the LSBs gives each buffer its own wrap.
  pe_addr_counter #(
    .width(maxAddrLen)
  ) u_addr_counter (
    .clk       (clk),
    .reset     (reset),
    .load      (cnt_load),
    .inc       (accept),
    .load_value(base_addr),
    .value     (cur_addr)
  );

  always_comb begin
    state_d        = state_q;
    sel_d          = sel_q;
    remaining_d    = remaining_q;
    done_d         = 1'b0;
    data_wrt_d     = 1'b0;
    data_addr_d    = data_addr_q;
    data_wdata_d   = data_wdata_q;
    weight_wrt_d   = 1'b0;
    weight_addr_d  = weight_addr_q;
    weight_wdata_d = weight_wdata_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (count != '0) begin
            sel_d       = sel;
            remaining_d = count;
            state_d     = ST_LOAD;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        if (accept) begin
          remaining_d = remaining_q - cntLen'(1);
          if (sel_q == SEL_DATA) begin
            data_wrt_d   = 1'b1;
            data_addr_d  = cur_addr[dataAddrLen-1:0];
            data_wdata_d = in_data;
          end else begin
            weight_wrt_d   = 1'b1;
            weight_addr_d  = cur_addr[weightAddrLen-1:0];
            weight_wdata_d = in_data;
          end
          // The last write strobe lands in the same cycle as done.
          if (remaining_q == cntLen'(1)) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      sel_q          <= SEL_DATA;
      remaining_q    <= '0;
      done_q         <= 1'b0;
      data_wrt_q     <= 1'b0;
      data_addr_q    <= '0;
      data_wdata_q   <= '0;
      weight_wrt_q   <= 1'b0;
      weight_addr_q  <= '0;
      weight_wdata_q <= '0;
    end else begin
      state_q        <= state_d;
      sel_q          <= sel_d;
      remaining_q    <= remaining_d;
      done_q         <= done_d;
      data_wrt_q     <= data_wrt_d;
      data_addr_q    <= data_addr_d;
      data_wdata_q   <= data_wdata_d;
      weight_wrt_q   <= weight_wrt_d;
      weight_addr_q  <= weight_addr_d;
      weight_wdata_q <= weight_wdata_d;
    end
  end

  assign in_ready        = (state_q == ST_LOAD);
  assign busy            = (state_q != ST_IDLE);
  assign done            = done_q;
  assign data_wrt        = data_wrt_q;
  assign data_wrt_addr   = data_addr_q;
  assign data_wr_data    = data_wdata_q;
  assign weight_wrt      = weight_wrt_q;
  assign weight_wrt_addr = weight_addr_q;
  assign weight_wr_data  = weight_wdata_q;

endmodule
